// File: rtl/fix12_to_float32_if.sv
// fix12_to_float32_if
//   One AXI4-Stream channel (tvalid/tready/tdata, plus tuser when
//   FIX12_TO_FLOAT32_TUSER_EN is defined). Instantiate one interface per direction.
//   master : drives tvalid/tdata/tuser, samples tready
//   slave  : samples tvalid/tdata/tuser, drives tready
interface fix12_to_float32_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
`ifdef FIX12_TO_FLOAT32_TUSER_EN
  logic [7:0]  tuser;

  modport master (output tvalid, output tdata, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tuser, output tready);
`else
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
`endif
endinterface

// File: rtl/fix12_to_float32.sv
// fix12_to_float32
//   Converts a signed 32-bit fixed-point sample (FRAC_BITS fractional bits)
//   into an IEEE-754 single. The stages are abs, lzc, normalise, round and pack.
//   The design accepts one sample per clock. A result appears 4 edges after
//   its input is accepted. The whole pipeline freezes while the output is
//   stalled.
// Ports
//   aclk          : clock, rising edge
//   aresetn       : asynchronous assert, active-low reset
//   s_axis_a      : slave stream, fixed-point input (value = tdata / 2^FRAC_BITS)
//   m_axis_result : master stream, {sign, exp[7:0], frac[22:0]}
// Options
//   FIX12_TO_FLOAT32_TUSER_EN : adds 8-bit tuser that follows its sample.
module fix12_to_float32 #(
  parameter int unsigned FRAC_BITS = 12
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  fix12_to_float32_if.slave    s_axis_a,
  fix12_to_float32_if.master   m_axis_result
);

  logic        released;
  logic        stall;
  logic        take;

  // S1: sign / magnitude
  logic        v1, sign1;
  logic [31:0] mag1;
  // S2: leading-zero count
  logic        v2, sign2, zero2;
  logic [31:0] mag2;
  logic [5:0]  lzc2;
  // S3: normalised value and biased exponent
  logic        v3, sign3, zero3;
  logic [30:0] norm3;
  logic [7:0]  exp3;
  // S4: rounded mantissa with carry bit
  logic        v4, sign4, zero4;
  logic [23:0] mant4;
  logic [7:0]  exp4;

  logic [31:0] mag_c;
  logic [5:0]  lzc_c;
  logic [9:0]  exp_c;
  logic        inc_c;
  logic [7:0]  pexp_c;

`ifdef FIX12_TO_FLOAT32_TUSER_EN
  logic [7:0]  user1, user2, user3, user4;
`endif

  assign stall           = m_axis_result.tvalid & ~m_axis_result.tready;
  assign s_axis_a.tready = released & ~stall;
  assign take            = s_axis_a.tvalid & s_axis_a.tready;

  always_comb begin
    // Two's-complement negate: 0x80000000 maps to 2^31, which still fits unsigned.
    mag_c = s_axis_a.tdata[31] ? (~s_axis_a.tdata + 32'd1) : s_axis_a.tdata;

    // The scan runs upward, so the highest set bit wins. Zero keeps 32.
    lzc_c = 6'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mag1[i]) lzc_c = 6'(31 - i);
    end

    exp_c = 10'd158 - 10'(lzc2) - 10'(FRAC_BITS);

    // Round to nearest, ties to even. Guard is bit 7, sticky is bits 6:0,
    // and the lsb is bit 8.
    inc_c = norm3[7] & ((|norm3[6:0]) | norm3[8]);

    // A carry out of the mantissa leaves the fraction bits all zero, so
    // only the exponent needs bumping.
    pexp_c = exp4 + {7'd0, mant4[23]};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      released             <= 1'b0;
      v1 <= 1'b0; sign1 <= 1'b0; mag1 <= '0;
      v2 <= 1'b0; sign2 <= 1'b0; zero2 <= 1'b0; mag2 <= '0; lzc2 <= '0;
      v3 <= 1'b0; sign3 <= 1'b0; zero3 <= 1'b0; norm3 <= '0; exp3 <= '0;
      v4 <= 1'b0; sign4 <= 1'b0; zero4 <= 1'b0; mant4 <= '0; exp4 <= '0;
      m_axis_result.tvalid <= 1'b0;
      m_axis_result.tdata  <= '0;
`ifdef FIX12_TO_FLOAT32_TUSER_EN
      user1 <= '0; user2 <= '0; user3 <= '0; user4 <= '0;
      m_axis_result.tuser <= '0;
`endif
    end else begin
      released <= 1'b1;
      if (!stall) begin
        v1    <= take;
        sign1 <= s_axis_a.tdata[31];
        mag1  <= mag_c;

        v2    <= v1;
        sign2 <= sign1;
        zero2 <= (mag1 == '0);
        mag2  <= mag1;
        lzc2  <= lzc_c;

        v3    <= v2;
        sign3 <= sign2;
        zero3 <= zero2;
        norm3 <= 31'(mag2 << lzc2);
        exp3  <= exp_c[7:0];

        v4    <= v3;
        sign4 <= sign3;
        zero4 <= zero3;
        mant4 <= {1'b0, norm3[30:8]} + {23'd0, inc_c};
        exp4  <= exp3;

        m_axis_result.tvalid <= v4;
        m_axis_result.tdata  <= zero4 ? '0 : {sign4, pexp_c, mant4[22:0]};
`ifdef FIX12_TO_FLOAT32_TUSER_EN
        user1 <= s_axis_a.tuser;
        user2 <= user1;
        user3 <= user2;
        user4 <= user3;
        m_axis_result.tuser <= user4;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fix12_to_float32.sv
module tb_fix12_to_float32;

  localparam int FRAC = 12;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  fix12_to_float32_if s_if ();
  fix12_to_float32_if m_if ();

  fix12_to_float32 #(.FRAC_BITS(FRAC)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_a      (s_if),
    .m_axis_result (m_if)
  );

`ifdef FIX12_TO_FLOAT32_TUSER_EN
  initial s_if.tuser = 8'h00;
`endif

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] e_v;

  // Independent reference: the magnitude is held in 64 bits, shifted right,
  // and rounded on the remainder.
  function automatic logic [31:0] model(input logic [31:0] x);
    logic        s;
    logic [63:0] m, q, rem, half;
    int          p, e, sh;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e = p + 127 - FRAC;
    if (p <= 23) q = m << (23 - p);
    else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    end
    return {s, e[7:0], q[22:0]};
  endfunction

  // Scoreboard: a transfer happens at the posedge that follows a negedge
  // where tvalid and tready are both high.
  always @(negedge aclk) begin
    if (!aresetn) sb_q.delete();
    else if (m_if.tvalid && m_if.tready) begin
      n_out++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h expected none", m_if.tdata);
      end else begin
        e_v = sb_q.pop_front();
        if (m_if.tdata !== e_v) begin
          errors++;
          $display("FAIL sb_data got %h expected %h", m_if.tdata, e_v);
        end
      end
    end
  end

  // Called at posedge+1. Returns at the posedge+1 after the input is accepted.
  task automatic send(input logic [31:0] d, input logic [31:0] e);
    int unsigned n = 0;
    bit ok = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    while (n < 200) begin
      @(negedge aclk);
      if (s_if.tready) begin ok = 1'b1; break; end
      n++;
    end
    if (ok) sb_q.push_back(e);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout got tready=0 expected 1 within 200 cycles");
    end
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge aclk); n++; end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb_q.size());
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      checks++;
      if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %b expected 0", s_if.tready); end
      checks++;
      if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b expected 0", m_if.tvalid); end
      checks++;
      if (m_if.tdata !== 32'h0) begin errors++; $display("FAIL rst_m_tdata got %h expected 0", m_if.tdata); end
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready got %b expected 1", s_if.tready); end
  endtask

  task automatic test_stream();
    m_if.tready = 1'b1;
    send(32'd10000, 32'h401C4000);
    fork
      for (int i = 0; i < 7; i++) send(32'd10000, 32'h401C4000);
      begin
        for (int c = 1; c <= 8; c++) begin
          @(posedge aclk); #1;
          checks++;
          if (m_if.tvalid !== ((c >= 4) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stream_latency edge+%0d got tvalid=%b expected %b", c, m_if.tvalid, (c >= 4));
          end
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_values();
    logic [31:0] vin[11] = '{32'hFFFFD8F0, 32'h0, 32'd4096, 32'd1, 32'h80000000,
                             32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'h04000007,
                             32'd10000, 32'hFFFFFFFF};
    logic [31:0] vexp[11] = '{32'hC01C4000, 32'h00000000, 32'h3F800000, 32'h39800000,
                              32'hC9000000, 32'h49000000, 32'h45800000, 32'h45800002,
                              32'h46800001, 32'h401C4000, 32'hB9800000};
    m_if.tready = 1'b1;
    for (int i = 0; i < 11; i++) send(vin[i], vexp[i]);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int  base = n_out;
    bit  done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 20; i++) send(32'(i), model(32'(i)));
        done = 1'b1;
      end
      begin
        logic        ps = 1'b0;
        logic [31:0] pd = '0;
        int unsigned cyc = 0;
        while ((!done || sb_q.size() != 0) && cyc < 1000) begin
          @(negedge aclk);
          cyc++;
          checks++;
          if (s_if.tready !== !(m_if.tvalid && !m_if.tready)) begin
            errors++;
            $display("FAIL bp_tready got %b expected %b", s_if.tready, !(m_if.tvalid && !m_if.tready));
          end
          if (ps) begin
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== pd) begin
              errors++;
              $display("FAIL bp_hold got %b/%h expected 1/%h", m_if.tvalid, m_if.tdata, pd);
            end
          end
          ps = m_if.tvalid && !m_if.tready;
          pd = m_if.tdata;
          @(posedge aclk); #1;
          m_if.tready = 1'($urandom_range(0, 1));
        end
        m_if.tready = 1'b1;
        if (cyc >= 1000) begin
          checks++; errors++;
          $display("FAIL bp_timeout got %0d pending expected 0", sb_q.size());
        end
      end
    join
    wait_drain();
    checks++;
    if (n_out - base != 20) begin errors++; $display("FAIL bp_count got %0d expected 20", n_out - base); end
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) send(32'(100 + i), model(32'(100 + i)));
    checks++;
    if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b expected 1", m_if.tvalid); end
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rm_valid_drop got %b expected 0", m_if.tvalid); end
    checks++;
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rm_tready got %b expected 0", s_if.tready); end
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (8) begin
      @(negedge aclk);
      checks++;
      if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rm_stale got tvalid=%b data=%h expected 0", m_if.tvalid, m_if.tdata); end
    end
    @(posedge aclk); #1;
    send(32'd7, model(32'd7));
    send(32'hFFFFFFFB, model(32'hFFFFFFFB));
    wait_drain();
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_stream();
    test_values();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
